// File: rtl/fifo_stream_reader_if.sv
`default_nettype none
// ============================================================================
// Module     : fifo_stream_reader_if
// Description: Bundles the FIFO-controller side (empty flag, read strobe,
//              read data) and the downstream valid/ready stream of the
//              FIFO stream reader.
// Revision   : 1.0 - initial release
// ============================================================================
interface fifo_stream_reader_if #(
  parameter int WIDTH = 32
);
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_rdata;
  logic             fifo_read;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             busy;

  // Reader side: consumes FIFO status/data and the consumer's ready.
  modport master (
    input  fifo_empty,
    input  fifo_rdata,
    input  out_ready,
    output fifo_read,
    output out_valid,
    output out_data,
    output busy
  );

  // Environment side: FIFO controller plus downstream consumer.
  modport slave (
    output fifo_empty,
    output fifo_rdata,
    output out_ready,
    input  fifo_read,
    input  out_valid,
    input  out_data,
    input  busy
  );
endinterface
`default_nettype wire

// File: rtl/fifo_stream_reader.sv
`default_nettype none
// ============================================================================
// Module     : fifo_stream_reader
// Description: Read-side engine for a FIFO buffer. Issues read strobes on a
//              credit basis, captures read data one cycle later into a
//              3-entry buffer and presents it on a valid/ready stream.
//              out_ready has no combinational path to fifo_read.
// Revision   : 1.0 - initial release
// ============================================================================
module fifo_stream_reader #(
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  fifo_stream_reader_if.master   stream_io
);

  localparam int         DEPTH    = 3;
  localparam logic [1:0] LAST_PTR = 2'd2;
  localparam logic [2:0] CREDITS  = 3'd3;

  logic [1:0]       count_q, count_d;
  logic [1:0]       wr_ptr_q, wr_ptr_d;
  logic [1:0]       rd_ptr_q, rd_ptr_d;
  logic             inflight_q;
  logic [WIDTH-1:0] buf_q [DEPTH];

  logic [2:0]       w_credit_used;
  logic             w_read;
  logic             w_capture;
  logic             w_pop;
  logic [WIDTH-1:0] w_head;

  // Pointers cycle through 0,1,2 only.
  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == LAST_PTR) ? 2'd0 : p + 2'd1;
  endfunction

  // Credit counts buffered words plus the word still on its way, so the
  // buffer can never be over-committed; only registered state is used.
  assign w_credit_used = {1'b0, count_q} + {2'b00, inflight_q};
  assign w_read        = ~reset & ~stream_io.fifo_empty & (w_credit_used < CREDITS);
  assign w_capture     = inflight_q;
  assign w_pop         = (count_q != 2'd0) & stream_io.out_ready;

  // Next-state for pointers and occupancy.
  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (w_capture) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (w_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    if (w_capture && !w_pop) begin
      count_d = count_q + 2'd1;
    end else if (!w_capture && w_pop) begin
      count_d = count_q - 2'd1;
    end
  end

  // Control state registers; reset drops any in-flight word.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q    <= 2'd0;
      wr_ptr_q   <= 2'd0;
      rd_ptr_q   <= 2'd0;
      inflight_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      inflight_q <= w_read;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    // Each entry captures read data when the write pointer selects it.
    always_ff @(posedge clk) begin
      if (reset) begin
        buf_q[i] <= '0;
      end else if (w_capture && (wr_ptr_q == 2'(i))) begin
        buf_q[i] <= stream_io.fifo_rdata;
      end
    end
  end

  // Head-of-buffer select; the unused pointer code falls back to entry 0.
  always_comb begin
    w_head = buf_q[0];
    case (rd_ptr_q)
      2'd1:    w_head = buf_q[1];
      2'd2:    w_head = buf_q[2];
      default: w_head = buf_q[0];
    endcase
  end

  assign stream_io.fifo_read = w_read;
  assign stream_io.out_valid = (count_q != 2'd0);
  assign stream_io.out_data  = w_head;
  assign stream_io.busy      = inflight_q | (count_q != 2'd0);

endmodule
`default_nettype wire

// File: tb/tb_fifo_stream_reader.sv
`default_nettype none
// ============================================================================
// Module     : tb_fifo_stream_reader
// Description: Self-checking bench for fifo_stream_reader. Emulates the FIFO
//              controller with a queue and predicts the reader with a
//              queue-based occupancy model.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_fifo_stream_reader;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fifo_stream_reader_if #(.WIDTH(32)) bus ();

  fifo_stream_reader #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .stream_io (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [31:0] src[$];        // words waiting inside the FIFO
  logic [31:0] mq[$];         // model: words buffered in the reader
  logic [31:0] delivered[$];  // words handed to the consumer
  bit          m_inf;         // model: a read was issued last cycle
  logic [31:0] m_inf_word;

  int cyc;
  int dut_reads;
  int run_len, max_run;
  int first_rd_cyc, first_vld_cyc;

  // One clock cycle: drive inputs after a falling edge, compare against the
  // model, then advance model and FIFO emulation across the rising edge.
  task automatic cycle(input bit rdy);
    bit          exp_rd;
    bit          do_pop;
    logic [31:0] w;
    w = 32'h0;
    bus.fifo_empty = (src.size() == 0);
    bus.out_ready  = rdy;
    #1;
    exp_rd = !reset && (src.size() != 0) && ((mq.size() + int'(m_inf)) < 3);
    checks++;
    if (bus.fifo_read !== exp_rd) begin
      errors++;
      $display("FAIL fifo_read cyc=%0d got=%b exp=%b", cyc, bus.fifo_read, exp_rd);
    end
    if (!reset) begin
      checks++;
      if (bus.out_valid !== (mq.size() != 0)) begin
        errors++;
        $display("FAIL out_valid cyc=%0d got=%b exp=%b", cyc, bus.out_valid, mq.size() != 0);
      end
      checks++;
      if (bus.busy !== (m_inf || mq.size() != 0)) begin
        errors++;
        $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, bus.busy, m_inf || mq.size() != 0);
      end
      if (mq.size() != 0) begin
        checks++;
        if (bus.out_data !== mq[0]) begin
          errors++;
          $display("FAIL out_data cyc=%0d got=%h exp=%h", cyc, bus.out_data, mq[0]);
        end
      end
    end
    if (bus.fifo_read === 1'b1) begin
      dut_reads++;
      run_len++;
      if (run_len > max_run) max_run = run_len;
      if (first_rd_cyc < 0) first_rd_cyc = cyc;
    end else begin
      run_len = 0;
    end
    if (bus.out_valid === 1'b1 && first_vld_cyc < 0) first_vld_cyc = cyc;
    do_pop = (mq.size() != 0) && rdy;
    if (exp_rd) w = src.pop_front();
    if (reset) begin
      mq.delete();
      m_inf = 1'b0;
    end else begin
      if (do_pop) delivered.push_back(mq.pop_front());
      if (m_inf) mq.push_back(m_inf_word);
      m_inf      = exp_rd;
      m_inf_word = w;
    end
    cyc++;
    @(negedge clk);
    bus.fifo_rdata = exp_rd ? w : $urandom;
  endtask

  task automatic clear_stats();
    delivered.delete();
    dut_reads = 0; run_len = 0; max_run = 0;
    first_rd_cyc = -1; first_vld_cyc = -1;
  endtask

  // mode 0: always ready, 1: alternating, 2: random
  task automatic drain(input int mode, input string name);
    int n;
    n = 0;
    while ((src.size() != 0 || mq.size() != 0 || m_inf) && n < 500) begin
      case (mode)
        0:       cycle(1'b1);
        1:       cycle(n[0] == 1'b0);
        default: cycle(1'($urandom_range(0, 1)));
      endcase
      n++;
    end
    checks++;
    if (n >= 500) begin
      errors++;
      $display("FAIL %s drain timeout got=%0d cycles required<500", name, n);
    end
  endtask

  task automatic check_delivered(input logic [31:0] exp_q[$], input string name);
    checks++;
    if (delivered.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s count got=%0d exp=%0d", name, delivered.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (delivered[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL %s word%0d got=%h exp=%h", name, i, delivered[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    src.delete();
    cycle(1'b0);
    cycle(1'b0);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.out_data !== 32'h0) begin
        errors++;
        $display("FAIL reset_out_data got=%h exp=00000000", bus.out_data);
      end
      cycle(1'b1);
    end
  endtask

  task automatic test_single();
    logic [31:0] exp_q[$];
    clear_stats();
    src.push_back(32'hDEADBEEF);
    exp_q.push_back(32'hDEADBEEF);
    drain(0, "single");
    for (int i = 0; i < 3; i++) cycle(1'b1);
    checks++;
    if (dut_reads != 1) begin
      errors++;
      $display("FAIL single_reads got=%0d exp=1", dut_reads);
    end
    checks++;
    if (first_vld_cyc - first_rd_cyc != 2) begin
      errors++;
      $display("FAIL single_latency got=%0d exp=2", first_vld_cyc - first_rd_cyc);
    end
    check_delivered(exp_q, "single");
  endtask

  task automatic test_stream();
    logic [31:0] exp_q[$];
    clear_stats();
    for (int i = 1; i <= 10; i++) begin
      src.push_back(32'(i));
      exp_q.push_back(32'(i));
    end
    drain(0, "stream");
    checks++;
    if (max_run != 10) begin
      errors++;
      $display("FAIL stream_consecutive_reads got=%0d exp=10", max_run);
    end
    check_delivered(exp_q, "stream");
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_q[$];
    clear_stats();
    for (int i = 1; i <= 6; i++) begin
      src.push_back(32'(i));
      exp_q.push_back(32'(i));
    end
    for (int i = 0; i < 8; i++) cycle(1'b0);
    checks++;
    if (dut_reads != 3) begin
      errors++;
      $display("FAIL bp_reads got=%0d exp=3", dut_reads);
    end
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'd1) begin
      errors++;
      $display("FAIL bp_head got=%b/%h exp=1/00000001", bus.out_valid, bus.out_data);
    end
    drain(0, "backpressure");
    checks++;
    if (dut_reads != 6) begin
      errors++;
      $display("FAIL bp_total_reads got=%0d exp=6", dut_reads);
    end
    check_delivered(exp_q, "backpressure");
  endtask

  task automatic test_alternating();
    logic [31:0] exp_q[$];
    logic [31:0] w;
    clear_stats();
    for (int i = 0; i < 8; i++) begin
      w = $urandom;
      src.push_back(w);
      exp_q.push_back(w);
    end
    drain(1, "alternating");
    check_delivered(exp_q, "alternating");
  endtask

  task automatic test_random();
    logic [31:0] exp_q[$];
    logic [31:0] w;
    clear_stats();
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 2) != 0) begin
        w = $urandom;
        src.push_back(w);
        exp_q.push_back(w);
      end
      cycle(1'($urandom_range(0, 1)));
    end
    drain(2, "random");
    check_delivered(exp_q, "random");
  endtask

  task automatic test_reset_midop();
    logic [31:0] exp_q[$];
    int n;
    clear_stats();
    for (int i = 0; i < 5; i++) src.push_back(32'hBAD0_0000 + 32'(i));
    n = 0;
    while (!(mq.size() == 2 && m_inf) && n < 20) begin
      cycle(1'b0);
      n++;
    end
    checks++;
    if (n >= 20) begin
      errors++;
      $display("FAIL midop_setup timeout got=%0d cycles required<20", n);
    end
    reset = 1'b1;
    src.delete();
    cycle(1'b0);
    reset = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL midop_after_reset got valid=%b busy=%b exp 0/0", bus.out_valid, bus.busy);
    end
    clear_stats();
    for (int i = 0; i < 4; i++) begin
      src.push_back(32'hC0DE_0000 + 32'(i));
      exp_q.push_back(32'hC0DE_0000 + 32'(i));
    end
    drain(0, "midop");
    check_delivered(exp_q, "midop");
  endtask

  initial begin
    reset          = 1'b1;
    bus.fifo_empty = 1'b1;
    bus.fifo_rdata = 32'h0;
    bus.out_ready  = 1'b0;
    m_inf          = 1'b0;
    m_inf_word     = 32'h0;
    cyc            = 0;
    clear_stats();
    @(negedge clk);
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_alternating();
    test_random();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
